// File: rtl/audio_env_pwm.sv
// ADSR envelope on a 1-bit generator stream, PWM-gated to the audio pin, with envelope status.
// Latency: i_Snd to o_Out is 2 cycles; state and level update on the same edge.
// Backpressure: none; free-running stream sink with no stall path.
module audio_env_pwm #(
    parameter int TICK_DIV      = 25000,
    parameter int ATTACK_STEP   = 8,
    parameter int DECAY_STEP    = 4,
    parameter int SUSTAIN_LEVEL = 160,
    parameter int RELEASE_STEP  = 2
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Gate,
    input  logic       i_Snd,
    output logic       o_Out,
    output logic [7:0] o_Level,
    output logic [2:0] o_State,
    output logic       o_Busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    state_t        state_q, state_d;
    logic [7:0]    level_q, level_d;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [7:0]    pwm_cnt;
    logic          r_snd;

    logic [8:0]    atk_sum;
    logic [7:0]    atk_lvl, dec_lvl, rel_lvl;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge i_Clk) begin
        if (i_Reset) tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else tick_cnt <= tick_cnt + TW'(1);
    end

    // Saturating level arithmetic in 9 bits so the clamps never see a wrapped value.
    always_comb begin
        atk_sum = {1'b0, level_q} + 9'(ATTACK_STEP);
        atk_lvl = (atk_sum > 9'd255) ? 8'd255 : atk_sum[7:0];
        dec_lvl = ({1'b0, level_q} >= (9'(DECAY_STEP) + 9'(SUSTAIN_LEVEL)))
                  ? (level_q - 8'(DECAY_STEP)) : 8'(SUSTAIN_LEVEL);
        rel_lvl = ({1'b0, level_q} > 9'(RELEASE_STEP))
                  ? (level_q - 8'(RELEASE_STEP)) : 8'd0;
    end

    // Gate changes win over a coincident tick; level holds on that edge.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        case (state_q)
            IDLE: begin
                if (i_Gate) state_d = ATTACK;
            end
            ATTACK: begin
                if (!i_Gate) state_d = RELEASE;
                else if (tick) begin
                    level_d = atk_lvl;
                    if (atk_lvl == 8'd255) state_d = DECAY;
                end
            end
            DECAY: begin
                if (!i_Gate) state_d = RELEASE;
                else if (tick) begin
                    level_d = dec_lvl;
                    if (dec_lvl == 8'(SUSTAIN_LEVEL)) state_d = SUSTAIN;
                end
            end
            SUSTAIN: begin
                if (!i_Gate) state_d = RELEASE;
            end
            RELEASE: begin
                if (i_Gate) state_d = ATTACK;
                else if (tick) begin
                    level_d = rel_lvl;
                    if (rel_lvl == 8'd0) state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                level_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= IDLE;
            level_q <= 8'd0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            pwm_cnt <= 8'd0;
            r_snd   <= 1'b0;
            o_Out   <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            r_snd   <= i_Snd;
            o_Out   <= r_snd & (pwm_cnt < level_q);
        end
    end

    assign o_Level = level_q;
    assign o_State = state_q;
    assign o_Busy  = (state_q != IDLE);

endmodule

// File: tb/tb_audio_env_pwm.sv
// Directed bench for audio_env_pwm with a fast tick (TICK_DIV=4) and large steps.
module tb_audio_env_pwm;

    logic       clk = 1'b0;
    logic       rst;
    logic       gate;
    logic       snd;
    logic       out;
    logic [7:0] level;
    logic [2:0] state;
    logic       busy;

    int checks = 0;
    int errors = 0;

    audio_env_pwm #(
        .TICK_DIV(4), .ATTACK_STEP(64), .DECAY_STEP(32),
        .SUSTAIN_LEVEL(128), .RELEASE_STEP(16)
    ) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Gate(gate), .i_Snd(snd),
        .o_Out(out), .o_Level(level), .o_State(state), .o_Busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       gate;
        logic       snd;
        int         n;
        logic [2:0] st;
        logic [7:0] lvl;
        logic       chk_out;
        logic       out;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic g, input logic s, input int n,
                       input logic [2:0] st, input logic [7:0] lvl,
                       input logic co, input logic o);
        vec_t v;
        v.rst = r; v.gate = g; v.snd = s; v.n = n;
        v.st = st; v.lvl = lvl; v.chk_out = co; v.out = o;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            rst  = vecs[i].rst;
            gate = vecs[i].gate;
            snd  = vecs[i].snd;
            step(vecs[i].n);
            check("state", i, int'(state), int'(vecs[i].st));
            check("level", i, int'(level), int'(vecs[i].lvl));
            check("busy",  i, int'(busy),  int'(vecs[i].st != 3'd0));
            if (vecs[i].chk_out) check("out", i, int'(out), int'(vecs[i].out));
        end
    endtask

    task automatic count_high(input string name, input int exp);
        int hi;
        hi = 0;
        for (int c = 0; c < 256; c++) begin
            step(1);
            if (out) hi++;
        end
        check(name, 0, hi, exp);
    endtask

    int split_a, split_b;

    initial begin
        // Attack/decay into sustain from reset (tick lands on every 4th edge after release of reset).
        add(0,1,1,1, 3'd1,   0, 0,0);
        add(0,1,1,3, 3'd1,  64, 0,0);
        add(0,1,1,4, 3'd1, 128, 0,0);
        add(0,1,1,4, 3'd1, 192, 0,0);
        add(0,1,1,4, 3'd2, 255, 0,0);
        add(0,1,1,4, 3'd2, 223, 0,0);
        add(0,1,1,4, 3'd2, 191, 0,0);
        add(0,1,1,4, 3'd2, 159, 0,0);
        add(0,1,1,4, 3'd3, 128, 0,0);
        add(0,1,1,4, 3'd3, 128, 0,0);
        split_a = vecs.size();
        // Release down to 64, then retrigger: attack resumes from 64.
        add(0,0,1,1, 3'd4, 128, 0,0);
        add(0,0,1,3, 3'd4, 112, 0,0);
        add(0,0,1,4, 3'd4,  96, 0,0);
        add(0,0,1,4, 3'd4,  80, 0,0);
        add(0,0,1,4, 3'd4,  64, 0,0);
        add(0,1,1,1, 3'd1,  64, 0,0);
        add(0,1,1,3, 3'd1, 128, 0,0);
        add(0,1,1,4, 3'd1, 192, 0,0);
        add(0,1,1,4, 3'd2, 255, 0,0);
        add(0,1,1,4, 3'd2, 223, 0,0);
        add(0,1,1,4, 3'd2, 191, 0,0);
        add(0,1,1,4, 3'd2, 159, 0,0);
        add(0,1,1,4, 3'd3, 128, 0,0);
        // Full release from sustain: 8 ticks of -16 back to IDLE.
        add(0,0,1,1, 3'd4, 128, 0,0);
        add(0,0,1,3, 3'd4, 112, 0,0);
        add(0,0,1,4, 3'd4,  96, 0,0);
        add(0,0,1,4, 3'd4,  80, 0,0);
        add(0,0,1,4, 3'd4,  64, 0,0);
        add(0,0,1,4, 3'd4,  48, 0,0);
        add(0,0,1,4, 3'd4,  32, 0,0);
        add(0,0,1,4, 3'd4,  16, 0,0);
        add(0,0,1,4, 3'd0,   0, 0,0);
        add(0,0,1,4, 3'd0,   0, 1,0);
        // Reset pulse mid-attack with the gate held; envelope restarts from 0.
        add(0,1,1,1, 3'd1,   0, 0,0);
        add(0,1,1,3, 3'd1,  64, 0,0);
        add(1,1,1,1, 3'd0,   0, 1,0);
        add(0,1,1,1, 3'd1,   0, 0,0);
        add(0,1,1,3, 3'd1,  64, 0,0);
        split_b = vecs.size();

        rst  = 1'b1;
        gate = 1'($urandom_range(0, 1));
        snd  = 1'($urandom_range(0, 1));
        step(1);
        gate = 1'($urandom_range(0, 1));
        snd  = 1'($urandom_range(0, 1));
        step(1);
        check("rst_out",   0, int'(out),   0);
        check("rst_level", 0, int'(level), 0);
        check("rst_state", 0, int'(state), 0);
        check("rst_busy",  0, int'(busy),  0);

        run_vecs(0, split_a);

        // Sustain at 128: exactly half duty with sound on, silent with sound off.
        // 256 + 4 + 256 edges keeps the tick phase aligned for the next vectors.
        count_high("pwm_duty128", 128);
        snd = 1'b0;
        step(4);
        count_high("pwm_snd0", 0);
        check("sustain_level", 0, int'(level), 128);
        check("sustain_state", 0, int'(state), 3);

        run_vecs(split_a, split_b);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
